rightshift_bridge: RTL and testbench



---
 rtl/rightshift_bridge_if.sv | 23 ++
 rtl/rightshift_bridge.sv | 140 ++++++++++++++
 tb/tb_rightshift_bridge.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rightshift_bridge_if.sv
// Bundled-data channel pair seen by the right-shift bridge: the 4-phase input channel
// from the router stage and the 4-phase output channel toward the injection/ejection port.
interface rightshift_bridge_if #(
  parameter int WIDTH = 11
);
  logic             in_req;
  logic [WIDTH-1:0] in_data;
  logic             in_fill;
  logic             in_ack;
  logic             out_req;
  logic [WIDTH-1:0] out_data;
  logic             out_ack;

  modport slave (
    input  in_req, in_data, in_fill, out_ack,
    output in_ack, out_req, out_data
  );

  modport master (
    output in_req, in_data, in_fill, out_ack,
    input  in_ack, out_req, out_data
  );
endinterface

// File: rtl/rightshift_bridge.sv
// Restores the route bit consumed by the router's left-shift stage: each accepted flit is
// stored as {fill, data[WIDTH-1:1]} in a small FIFO and replayed on a 4-phase output channel.
module rightshift_bridge #(
  parameter int WIDTH       = 11,
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 2
) (
  input  logic               clk,
  input  logic               reset,
  rightshift_bridge_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [0:0] I_IDLE  = 1'b0;
  localparam logic [0:0] I_ACK   = 1'b1;
  localparam logic [1:0] O_IDLE  = 2'd0;
  localparam logic [1:0] O_SETUP = 2'd1;
  localparam logic [1:0] O_WAIT  = 2'd2;
  localparam logic [1:0] O_RTZ   = 2'd3;

  logic [SYNC_STAGES-1:0] req_sync_q, ack_sync_q;
  logic                   req_s, ack_s;

  logic [0:0]       in_state_q, in_state_d;
  logic [1:0]       out_state_q, out_state_d;
  logic             in_ack_q, in_ack_d;
  logic             out_req_q, out_req_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop, full, empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_sync_q <= '0;
      ack_sync_q <= '0;
    end else begin
      req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], bus.in_req};
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], bus.out_ack};
    end
  end

  assign req_s = req_sync_q[SYNC_STAGES-1];
  assign ack_s = ack_sync_q[SYNC_STAGES-1];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  always_comb begin
    out_state_d = out_state_q;
    out_req_d   = out_req_q;
    out_data_d  = out_data_q;
    in_state_d  = in_state_q;
    in_ack_d    = in_ack_q;
    push        = 1'b0;
    pop         = 1'b0;

    // Output side is decoded first so a pop can free the slot a same-edge push needs.
    case (out_state_q)
      O_IDLE: begin
        if (!empty) begin
          out_data_d  = mem[rd_ptr_q];
          out_state_d = O_SETUP;
        end
      end
      O_SETUP: begin
        out_req_d   = 1'b1;
        out_state_d = O_WAIT;
      end
      O_WAIT: begin
        if (ack_s) begin
          out_req_d   = 1'b0;
          pop         = 1'b1;
          out_state_d = O_RTZ;
        end
      end
      default: begin
        if (!ack_s) out_state_d = O_IDLE;
      end
    endcase

    case (in_state_q)
      I_IDLE: begin
        if (req_s && (!full || pop)) begin
          push       = 1'b1;
          in_ack_d   = 1'b1;
          in_state_d = I_ACK;
        end
      end
      default: begin
        if (!req_s) begin
          in_ack_d   = 1'b0;
          in_state_d = I_IDLE;
        end
      end
    endcase

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_state_q  <= I_IDLE;
      out_state_q <= O_IDLE;
      in_ack_q    <= 1'b0;
      out_req_q   <= 1'b0;
      out_data_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      in_state_q  <= in_state_d;
      out_state_q <= out_state_d;
      in_ack_q    <= in_ack_d;
      out_req_q   <= out_req_d;
      out_data_q  <= out_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Storage needs no reset: occupancy is tracked entirely by count_q.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {bus.in_fill, bus.in_data[WIDTH-1:1]};
  end

  assign bus.in_ack   = in_ack_q;
  assign bus.out_req  = out_req_q;
  assign bus.out_data = out_data_q;
endmodule

// File: tb/tb_rightshift_bridge.sv
// Directed and scoreboard checks for the right-shift bridge: reset, latency, transform
// vectors, FIFO backpressure, reset mid-handshake and randomized back-to-back traffic.
module tb_rightshift_bridge;
  localparam int W     = 11;
  localparam int LIMIT = 200;

  typedef struct {
    logic [W-1:0] data;
    logic         fill;
    logic [W-1:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic resp_en  = 1'b0;
  logic resp_ack = 1'b0;
  logic man_ack  = 1'b0;
  int   resp_dly = 0;
  int   checks   = 0;
  int   passed   = 0;
  logic [W-1:0] got[$];
  logic [W-1:0] sb[$];
  vec_t vecs[8];

  rightshift_bridge_if #(.WIDTH(W)) bus ();

  rightshift_bridge #(.WIDTH(W), .SYNC_STAGES(2), .DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.out_ack = resp_ack | man_ack;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] pop_got();
    if (got.size() == 0) return '1;
    return 32'(got.pop_front());
  endfunction

  // Posedge-aligned wait on in_ack (sel=0) or out_req (sel=1); n = edges waited.
  task automatic wait_sig(input bit sel, input logic lvl, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (((sel ? bus.out_req : bus.in_ack) !== lvl) && n < LIMIT);
  endtask

  task automatic send(input logic [W-1:0] d, input logic f);
    int n;
    @(negedge clk);
    bus.in_data = d;
    bus.in_fill = f;
    bus.in_req  = 1'b1;
    wait_sig(0, 1'b1, n);
    check("in_ack_rise", 32'(bus.in_ack), 1);
    @(negedge clk);
    bus.in_req = 1'b0;
    wait_sig(0, 1'b0, n);
    check("in_ack_fall", 32'(bus.in_ack), 0);
  endtask

  task automatic wait_got(input int k);
    int t;
    t = 0;
    while (got.size() < k && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("got_count", 32'(got.size() >= k), 1);
  endtask

  // Output-channel responder: records each flit, then completes the 4-phase handshake.
  initial begin
    int t;
    forever begin
      @(negedge clk);
      if (resp_en && bus.out_req && !bus.out_ack) begin
        got.push_back(bus.out_data);
        $display("rx flit %03h", bus.out_data);
        repeat ($urandom_range(0, resp_dly)) @(negedge clk);
        resp_ack = 1'b1;
        t = 0;
        while (bus.out_req && t < LIMIT) begin
          @(negedge clk);
          t++;
        end
        check("rsp_out_req_fall", 32'(bus.out_req), 0);
        resp_ack = 1'b0;
        repeat ($urandom_range(0, resp_dly)) @(negedge clk);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, ack_edge, req_edge;
    logic [W-1:0] d;
    logic         f;

    vecs[0] = '{11'b01010100111, 1'b0, 11'b00101010011};
    vecs[1] = '{11'b11011100100, 1'b1, 11'b11101110010};
    vecs[2] = '{11'h7FF, 1'b0, 11'h3FF};
    vecs[3] = '{11'h000, 1'b1, 11'h400};
    vecs[4] = '{11'h001, 1'b1, 11'h400};
    vecs[5] = '{11'h555, 1'b0, 11'h2AA};
    vecs[6] = '{11'h2AA, 1'b1, 11'h555};
    vecs[7] = '{11'h400, 1'b0, 11'h200};

    reset       = 1'b1;
    bus.in_req  = 1'b0;
    bus.in_data = '0;
    bus.in_fill = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ack", 32'(bus.in_ack), 0);
    check("rst_out_req", 32'(bus.out_req), 0);
    check("rst_out_data", 32'(bus.out_data), 0);
    reset = 1'b0;

    // Latency from in_req rise: in_ack on edge 3, out_req on edge 5.
    resp_en  = 1'b1;
    resp_dly = 0;
    @(negedge clk);
    bus.in_data = 11'b01010100111;
    bus.in_fill = 1'b0;
    bus.in_req  = 1'b1;
    n = 0; ack_edge = 0; req_edge = 0;
    while (req_edge == 0 && n < LIMIT) begin
      @(posedge clk); #1;
      n++;
      if (bus.in_ack && ack_edge == 0) ack_edge = n;
      if (bus.out_req) req_edge = n;
    end
    check("lat_in_ack", ack_edge, 3);
    check("lat_out_req", req_edge, 5);
    @(negedge clk);
    bus.in_req = 1'b0;
    wait_sig(0, 1'b0, n);
    check("lat_in_ack_fall", 32'(bus.in_ack), 0);
    wait_got(1);
    check("lat_data", pop_got(), 32'h153);

    // Transform vectors, one token at a time.
    resp_dly = 2;
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].data, vecs[i].fill);
      wait_got(1);
      check($sformatf("vec%0d", i), pop_got(), 32'(vecs[i].exp));
    end

    // Backpressure: output stalled, two tokens fill the FIFO, the third must wait.
    resp_en = 1'b0;
    repeat (20) @(negedge clk);
    send(11'h001, 1'b0);
    send(11'h002, 1'b0);
    @(negedge clk);
    bus.in_data = 11'h003;
    bus.in_fill = 1'b0;
    bus.in_req  = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("bp_in_ack_low", 32'(bus.in_ack), 0);
    check("bp_out_req", 32'(bus.out_req), 1);
    check("bp_head", 32'(bus.out_data), 32'h000);
    @(negedge clk);
    man_ack = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (bus.out_req && !bus.in_ack && n < LIMIT);
    check("bp_pop_edge", n, 3);
    check("bp_push_same_edge", 32'(bus.in_ack), 1);
    check("bp_out_req_fall", 32'(bus.out_req), 0);
    @(negedge clk);
    bus.in_req = 1'b0;
    man_ack    = 1'b0;
    wait_sig(0, 1'b0, n);
    check("bp_in_ack_fall", 32'(bus.in_ack), 0);
    resp_en = 1'b1;
    wait_got(2);
    check("bp_out2", pop_got(), 32'h001);
    check("bp_out3", pop_got(), 32'h001);

    // Reset while waiting for out_ack with one flit buffered and in_ack still high.
    resp_en = 1'b0;
    repeat (20) @(negedge clk);
    @(negedge clk);
    bus.in_data = 11'h123;
    bus.in_fill = 1'b1;
    bus.in_req  = 1'b1;
    wait_sig(0, 1'b1, n);
    check("rt_in_ack", 32'(bus.in_ack), 1);
    wait_sig(1, 1'b1, n);
    check("rt_out_req", 32'(bus.out_req), 1);
    #2;
    reset      = 1'b1;
    bus.in_req = 1'b0;
    #1;
    check("rt_out_req_drop", 32'(bus.out_req), 0);
    check("rt_in_ack_drop", 32'(bus.in_ack), 0);
    check("rt_out_data_clr", 32'(bus.out_data), 0);
    repeat (2) @(negedge clk);
    reset   = 1'b0;
    resp_en = 1'b1;
    repeat (40) @(negedge clk);
    check("rt_no_emit", got.size(), 0);
    check("rt_out_req_idle", 32'(bus.out_req), 0);
    send(11'h0F0, 1'b1);
    wait_got(1);
    check("rt_after", pop_got(), 32'h478);

    // Randomized back-to-back traffic against an in-order scoreboard.
    resp_dly = 7;
    for (int i = 0; i < 8; i++) begin
      d = W'($urandom);
      f = 1'($urandom);
      sb.push_back({f, d[W-1:1]});
      repeat ($urandom_range(0, 7)) @(negedge clk);
      send(d, f);
    end
    wait_got(8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("rand%0d", i), pop_got(), 32'(sb.pop_front()));
    end
    repeat (50) @(negedge clk);
    check("rand_no_extra", got.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
